// File: rtl/pio_svc_pkg.sv
// pio_svc_pkg: FSM states and PIO register offsets shared by pio_irq_service_master
package pio_svc_pkg;
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_MASK, S_CAP_A, S_CAP_D, S_CLR, S_LVL_A, S_LVL_D, S_PUSH
  } state_t;
  localparam logic [1:0] PIO_OFS_DATA = 2'd0;
  localparam logic [1:0] PIO_OFS_MASK = 2'd2;
  localparam logic [1:0] PIO_OFS_EDGE = 2'd3;
endpackage

// File: rtl/pio_irq_service_master.sv
// pio_irq_service_master: Avalon-MM master servicing PIO IRQs into an event stream; PIO_SVC_TIMESTAMP_EN adds evt_time
module pio_irq_service_master
  import pio_svc_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT = '1,
  parameter int TS_WIDTH = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq,
  output logic [1:0] avm_address,
  output logic avm_chipselect,
  output logic avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic cfg_mask_wr,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic busy,
  output logic evt_valid,
  input  logic evt_ready,
  output logic [WIDTH-1:0] evt_capture,
`ifdef PIO_SVC_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0] evt_time,
`endif
  output logic [WIDTH-1:0] evt_level
);
  state_t state, nxt;
  logic pend;
  logic [WIDTH-1:0] mask_q, mask_nx, bus_wd, rd;
  logic bus_cs, bus_wn;
  logic [1:0] bus_addr;
  logic unused_rd;
  assign rd = avm_readdata[WIDTH-1:0];
  assign unused_rd = ^avm_readdata[31:WIDTH];
  assign mask_nx = cfg_mask_wr ? cfg_mask : mask_q;
  always_comb begin
    nxt = state;
    case (state)
      S_INIT:  nxt = avm_chipselect ? S_IDLE : S_INIT;
      S_IDLE:  nxt = pend ? S_MASK : irq ? S_CAP_A : S_IDLE;
      S_MASK:  nxt = S_IDLE;
      S_CAP_A: nxt = S_CAP_D;
      S_CAP_D: nxt = |rd ? S_CLR : S_IDLE;
      S_CLR:   nxt = S_LVL_A;
      S_LVL_A: nxt = S_LVL_D;
      S_LVL_D: nxt = S_PUSH;
      S_PUSH:  nxt = evt_ready ? S_IDLE : S_PUSH;
      default: nxt = S_INIT;
    endcase
    bus_cs = nxt inside {S_INIT, S_MASK, S_CAP_A, S_CLR, S_LVL_A};
    bus_wn = !(nxt inside {S_INIT, S_MASK, S_CLR});
    bus_addr = (nxt == S_CAP_A || nxt == S_CLR) ? PIO_OFS_EDGE :
               (nxt == S_INIT || nxt == S_MASK) ? PIO_OFS_MASK : PIO_OFS_DATA;
    bus_wd = nxt == S_INIT ? IRQ_MASK_INIT : nxt == S_MASK ? mask_nx : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_INIT;
      avm_chipselect <= 1'b0;
      avm_write_n <= 1'b1;
      avm_address <= PIO_OFS_DATA;
      avm_writedata <= '0;
      evt_valid <= 1'b0;
      evt_capture <= '0;
      evt_level <= '0;
      busy <= 1'b1;
      pend <= 1'b0;
      mask_q <= '0;
    end else begin
      state <= nxt;
      avm_chipselect <= bus_cs;
      avm_write_n <= bus_wn;
      avm_address <= bus_addr;
      avm_writedata <= 32'(bus_wd);
      evt_valid <= nxt == S_PUSH;
      evt_capture <= state == S_CAP_D ? rd : evt_capture;
      evt_level <= state == S_LVL_D ? rd : evt_level;
      busy <= nxt != S_IDLE;
      pend <= cfg_mask_wr | (pend & (state != S_MASK));
      mask_q <= mask_nx;
    end
  end
`ifdef PIO_SVC_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts <= '0;
      evt_time <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      evt_time <= (state == S_IDLE && nxt == S_CAP_A) ? ts : evt_time;
    end
  end
`else
  localparam int unused_ts = TS_WIDTH;
`endif
endmodule

// File: tb/tb_pio_irq_service_master.sv
// tb_pio_irq_service_master: PIO slave model plus transaction-level reference for the IRQ service master
module tb_pio_irq_service_master;
  import pio_svc_pkg::*;
  logic clk = 0, reset_n = 0, cfg_mask_wr = 0, evt_ready = 1, irq;
  logic [2:0] cfg_mask = 0;
  logic [31:0] avm_readdata = 0;
  logic [1:0] avm_address;
  logic avm_chipselect, avm_write_n, busy, evt_valid;
  logic [31:0] avm_writedata;
  logic [2:0] evt_capture, evt_level;
`ifdef PIO_SVC_TIMESTAMP_EN
  logic [31:0] evt_time;
`endif
  pio_irq_service_master dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .cfg_mask_wr(cfg_mask_wr), .cfg_mask(cfg_mask),
    .busy(busy), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_capture(evt_capture),
`ifdef PIO_SVC_TIMESTAMP_EN
    .evt_time(evt_time),
`endif
    .evt_level(evt_level)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  // PIO slave: edge capture with clear priority, registered readdata
  logic [2:0] sl_edge = 0, sl_mask = 0, sl_level = 0, inj = 0;
  logic sl_irq = 0, force_irq = 0;
  logic s_cs = 0, s_wn = 1;
  logic [1:0] s_addr = 0;
  logic [31:0] s_wd = 0;
  logic q_rst = 1, q_wr = 0, q_ready = 0;
  logic [2:0] q_mask = 0;
  assign irq = sl_irq | force_irq;
  always @(posedge clk) begin
    q_rst = !reset_n;
    q_wr = cfg_mask_wr;
    q_mask = cfg_mask;
    q_ready = evt_ready;
    #1;
    avm_readdata = (s_cs && s_wn) ?
      (s_addr == PIO_OFS_EDGE ? {29'b0, sl_edge} : s_addr == PIO_OFS_DATA ? {29'b0, sl_level} :
       s_addr == PIO_OFS_MASK ? {29'b0, sl_mask} : 32'h0) : 32'h0;
    if (s_cs && !s_wn && s_addr == PIO_OFS_MASK) sl_mask = s_wd[2:0];
    sl_edge = (s_cs && !s_wn && s_addr == PIO_OFS_EDGE) ? 3'b000 : (sl_edge | inj);
    sl_irq = |(sl_edge & sl_mask);
  end
  // reference model: expected bus sequence per service and expected event records
  typedef struct { logic [2:0] cap; logic [2:0] lvl; logic [31:0] t; } ev_t;
  ev_t exp_q[$];
  ev_t e;
  int svc_t = -1, ev_cnt = 0, rd3_cnt = 0, wr_cnt = 0;
  logic spur = 0, m_pend = 0, init_pend = 1, prev_valid = 0;
  logic [2:0] mask_exp = 3'd7, cur_cap = 0, cur_lvl = 0, prev_cap = 0, prev_lvl = 0, last_cap = 0, last_lvl = 0;
  logic [31:0] tb_ts = 0, exp_ts = 0, prev_time = 0;
  always @(negedge clk) begin
    if (q_rst) begin
      svc_t = -1; spur = 0; exp_q.delete();
      mask_exp = 3'd7; m_pend = 0; init_pend = 1; tb_ts = 0;
    end else begin
      tb_ts++;
      if (q_wr) begin mask_exp = q_mask; m_pend = 1; end
      if (prev_valid && q_ready) begin
        check("evt_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("evt_capture", prev_cap, e.cap);
          check("evt_level", prev_lvl, e.lvl);
`ifdef PIO_SVC_TIMESTAMP_EN
          check("evt_time", prev_time, e.t);
`endif
        end
        ev_cnt++; last_cap = prev_cap; last_lvl = prev_lvl;
      end else if (prev_valid)
        check("evt_hold", {evt_valid, evt_capture, evt_level}, {1'b1, prev_cap, prev_lvl});
      if (evt_valid) check("push_bus_idle", avm_chipselect, 0);
      if (avm_chipselect && !avm_write_n) wr_cnt++;
      if (avm_chipselect && !avm_write_n && avm_address == PIO_OFS_MASK) begin
        check("mask_requested", init_pend | m_pend, 1);
        check("mask_wdata", avm_writedata, {29'b0, mask_exp});
        init_pend = 0; m_pend = 0;
      end
      if (spur) check("spurious_no_clear", avm_chipselect && !avm_write_n && avm_address == PIO_OFS_EDGE, 0);
      spur = 0;
      if (svc_t >= 0) svc_t++;
      if (avm_chipselect && avm_write_n && avm_address == PIO_OFS_EDGE) begin
        rd3_cnt++;
        check("rd3_when_idle", svc_t < 0, 1);
        svc_t = 0; exp_ts = tb_ts - 1;
      end
      if (svc_t == 1) begin
        check("capd_bus_idle", avm_chipselect, 0);
        cur_cap = avm_readdata[2:0];
        if (cur_cap == 0) begin svc_t = -1; spur = 1; end
      end else if (svc_t == 2)
        check("clear_op", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b1, 1'b0, PIO_OFS_EDGE, 32'h0});
      else if (svc_t == 3)
        check("level_op", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, PIO_OFS_DATA});
      else if (svc_t == 4) begin
        check("lvld_idle_novalid", {avm_chipselect, evt_valid}, 2'b00);
        cur_lvl = avm_readdata[2:0];
      end else if (svc_t == 5) begin
        check("evt_latency", evt_valid, 1);
        e.cap = cur_cap; e.lvl = cur_lvl; e.t = exp_ts;
        exp_q.push_back(e);
        svc_t = -1;
      end
    end
    prev_valid = evt_valid; prev_cap = evt_capture; prev_lvl = evt_level;
`ifdef PIO_SVC_TIMESTAMP_EN
    prev_time = evt_time;
`endif
    s_cs = avm_chipselect; s_wn = avm_write_n; s_addr = avm_address; s_wd = avm_writedata;
  end
  task automatic step();
    @(negedge clk);
    inj = 0; force_irq = 0; cfg_mask_wr = 0;
  endtask
  task automatic wait_op(input logic [1:0] a, input logic wn, input int budget, input string tag);
    int i = 0;
    while (!(avm_chipselect && avm_write_n == wn && avm_address == a) && i < budget) begin step(); i++; end
    check(tag, i < budget, 1);
  endtask
  task automatic wait_valid(input int budget, input string tag);
    int i = 0;
    while (!evt_valid && i < budget) begin step(); i++; end
    check(tag, i < budget, 1);
  endtask
  task automatic wait_events(input int n, input int budget, input string tag);
    int i = 0;
    while (ev_cnt < n && i < budget) begin step(); i++; end
    check(tag, i < budget, 1);
  endtask
  int e0, r0, w0, ev_rand;
  initial begin
    repeat (3) step();
    check("rst_cs", avm_chipselect, 0);
    check("rst_write_n", avm_write_n, 1);
    check("rst_address", avm_address, 0);
    check("rst_writedata", avm_writedata, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_busy", busy, 1);
    check("rst_capture_level", {evt_capture, evt_level}, 0);
`ifdef PIO_SVC_TIMESTAMP_EN
    check("rst_evt_time", evt_time, 0);
`endif
    reset_n = 1;
    step();
    check("init_write", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b1, 1'b0, PIO_OFS_MASK, 32'h7});
    check("init_busy", busy, 1);
    step();
    check("init_done", {busy, avm_chipselect, evt_valid}, 3'b000);
    // single service
    sl_level = 3'b011; inj = 3'b010; e0 = ev_cnt;
    wait_events(e0 + 1, 40, "svc_timeout");
    check("svc_cap", last_cap, 3'b010);
    check("svc_lvl", last_lvl, 3'b011);
    repeat (3) step();
    // spurious irq: edge capture empty
    r0 = rd3_cnt; w0 = wr_cnt; e0 = ev_cnt;
    force_irq = 1;
    repeat (7) step();
    check("spur_reads", rd3_cnt - r0, 1);
    check("spur_writes", wr_cnt - w0, 0);
    check("spur_events", ev_cnt - e0, 0);
    check("spur_idle", busy, 0);
    // backpressure with second irq pending
    evt_ready = 0; inj = 3'b001; e0 = ev_cnt;
    wait_valid(40, "bp_valid_timeout");
    inj = 3'b100;
    repeat (20) step();
    check("bp_still_valid", evt_valid, 1);
    check("bp_no_accept", ev_cnt - e0, 0);
    evt_ready = 1;
    wait_events(e0 + 2, 60, "bp_timeout");
    check("bp_second_cap", last_cap, 3'b100);
    repeat (3) step();
    // mask request arriving during a service
    inj = 3'b001; e0 = ev_cnt;
    step();
    wait_op(PIO_OFS_EDGE, 1'b1, 20, "m5_rd3_timeout");
    cfg_mask_wr = 1; cfg_mask = 3'b100;
    step();
    wait_op(PIO_OFS_DATA, 1'b1, 20, "m5_rd0_timeout");
    step();
    inj = 3'b100;
    step();
    check("m5_push", evt_valid, 1);
    step();
    check("m5_idle", {busy, avm_chipselect}, 2'b00);
    step();
    check("m5_mask_first", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b1, 1'b0, PIO_OFS_MASK, 32'h4});
    step();
    check("m5_gap", avm_chipselect, 0);
    step();
    check("m5_then_irq", {avm_chipselect, avm_write_n, avm_address}, {1'b1, 1'b1, PIO_OFS_EDGE});
    wait_events(e0 + 2, 40, "m5_timeout");
    check("m5_cap", last_cap, 3'b100);
    repeat (3) step();
    // reset during level read
    inj = 3'b100; e0 = ev_cnt;
    step();
    wait_op(PIO_OFS_DATA, 1'b1, 20, "r6_rd0_timeout");
    reset_n = 0;
    step();
    check("r6_bus_idle", {avm_chipselect, avm_write_n}, 2'b01);
    check("r6_valid_busy", {evt_valid, busy}, 2'b01);
`ifdef PIO_SVC_TIMESTAMP_EN
    check("r6_evt_time", evt_time, 0);
`endif
    reset_n = 1;
    step();
    check("r6_init_write", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b1, 1'b0, PIO_OFS_MASK, 32'h7});
    repeat (10) step();
    check("r6_no_event", ev_cnt - e0, 0);
    check("r6_idle", busy, 0);
    // randomized traffic
    e0 = ev_cnt;
    for (int i = 0; i < 2000; i++) begin
      step();
      evt_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) == 0) inj = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) sl_level = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin cfg_mask_wr = 1; cfg_mask = 3'($urandom_range(1, 7)); end
    end
    evt_ready = 1;
    repeat (30) step();
    ev_rand = ev_cnt - e0;
    check("rand_events", ev_rand > 20, 1);
    check("drain_queue", exp_q.size(), 0);
    check("drain_mask", m_pend, 0);
    check("drain_idle", {busy, evt_valid}, 2'b00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
